store_merge_unit: RTL and testbench
===================================

Name: store_merge_unit

Overview:
- Store-side counterpart of the load extension path. Takes a register value and a store type (sd/sw/sh/sb) and writes only the selected bytes into the 64-bit data memory.
- Partial stores use read-modify-write: read the old doubleword, merge the register bytes at the addressed lane, write the doubleword back.
- Sits between the EX/MEM stage control and the doubleword-wide data memory. Holds the pipeline via `busy` until the store completes.

Parameters:
- ADDR_W, 64, byte-address width.
- DATA_W, 64, memory word width; fixed at 64, other values unsupported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- st_start  in  1  one-cycle request; sampled only in IDLE.
- st_type  in  2  00 sd, 01 sw, 10 sh, 11 sb; same encoding slots as the load path.
- st_addr  in  ADDR_W  byte address of the store.
- st_data  in  64  register value; the low 8/16/32/64 bits are stored.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the store completes or is rejected.
- misaligned  out  1  valid with done; 1 = store rejected, memory untouched.
- mem_addr  out  ADDR_W  doubleword address: st_addr with bits [2:0] forced to 0.
- mem_rd  out  1  read request.
- mem_rdata  in  64  read data.
- mem_rvalid  in  1  read data valid; 1 or more cycles after mem_rd.
- mem_wr  out  1  write strobe, one cycle.
- mem_wdata  out  64  merged doubleword.

Behaviour:
- Reset (async, reset_n=0): state IDLE.
  - busy, done, misaligned, mem_rd, mem_wr = 0.
  - mem_addr, mem_wdata = 0.
  - Internal latches cleared.
- IDLE, st_start=1: latch st_type, st_addr, st_data; busy=1 from the next cycle.
  - Misalignment check: sd needs addr[2:0]=0; sw needs addr[1:0]=0; sh needs addr[0]=0; sb is always aligned.
  - Misaligned → REJECT. sd aligned → WRITE (no read). Other aligned → READ.
- READ: mem_rd=1 for exactly one cycle, mem_addr driven → WAIT.
- WAIT: mem_rd=0; hold until mem_rvalid=1. On that cycle, capture mem_rdata into the merge register → WRITE.
  - mem_rvalid in any other state is ignored.
- WRITE: mem_wr=1 for one cycle with the merged mem_wdata and mem_addr → DONE.
- Merge rule, with off = addr[2:0]:
  - sd: wdata = st_data.
  - sw: bytes [off+3:off] = st_data[31:0].
  - sh: bytes [off+1:off] = st_data[15:0].
  - sb: byte [off] = st_data[7:0].
  - All other bytes keep the captured read data.
  - No sign or zero extension on the store side.
- DONE: done=1, misaligned=0 for one cycle → IDLE.
- REJECT: done=1, misaligned=1 for one cycle → IDLE. No mem_rd or mem_wr is ever asserted for a rejected store.
- Latency, start to done pulse:
  - sd: 2 cycles.
  - Partial stores with 1-cycle read latency: 4 cycles.
  - Rejected store: 1 cycle.
- st_start while busy: ignored, not queued. Next request accepted no earlier than the cycle after done.
- Reset mid-operation: returns to IDLE immediately.
  - No write is issued after reset deasserts.
  - A pending mem_rvalid that arrives later is ignored.
- mem_wr and mem_rd are never high in the same cycle.

Test Plan:
- Reset then sd: addr=0x40, data=0x1122334455667788.
  - Expect mem_rd never asserted; mem_wr with wdata=0x1122334455667788 at addr 0x40.
  - done 2 cycles after start; misaligned=0.
- sw to upper word: addr=0x84, data=0xFFFFFFFF_DEADBEEF, mem_rdata=0x0123456789ABCDEF.
  - Expect mem_addr=0x80 and wdata=0xDEADBEEF89ABCDEF.
- sh at offset 6: mem_rdata=0, data=0xA5A5.
  - Expect wdata=0xA5A5000000000000.
- sb at offset 3: mem_rdata=all-ones, data=0x00.
  - Expect wdata=0xFFFFFFFF00FFFFFF.
- Misaligned stores: sw at 0x102, sh at 0x101, sd at 0x104.
  - Each gives a one-cycle done with misaligned=1.
  - mem_rd and mem_wr stay 0 throughout.
- Stall, ignored start, and reset:
  - sb with mem_rvalid delayed 5 cycles: busy stays 1 and st_start pulses during busy are ignored.
  - Repeat the same sb and assert reset_n=0 while in WAIT: outputs go to 0 asynchronously and no mem_wr follows.

Source files
------------

// File: rtl/store_merge_unit_if.sv
// store_merge_unit_if
// Purpose : doubleword-wide data memory bus between the store merge unit
//           (master) and the data memory (slave).
// Signals : mem_addr   - doubleword-aligned byte address
//           mem_rd     - one-cycle read request
//           mem_rdata  - read data returned by memory
//           mem_rvalid - read data valid, one or more cycles after mem_rd
//           mem_wr     - one-cycle write strobe
//           mem_wdata  - doubleword to write
interface store_merge_unit_if #(
    parameter int ADDR_W = 64
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [63:0]       mem_rdata;
    logic              mem_rvalid;
    logic              mem_wr;
    logic [63:0]       mem_wdata;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_rvalid
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/store_merge_unit.sv
// store_merge_unit
// Purpose : writes the low 8/16/32/64 bits of a register into a 64-bit data
//           memory. Doubleword stores write directly; narrower stores read
//           the old doubleword, merge the new bytes at the addressed lane and
//           write the result back. Misaligned stores are rejected without
//           touching memory.
// Ports   : clk, reset_n   - clock, asynchronous active-low reset
//           st_start       - one-cycle store request, sampled only when idle
//           st_type        - 00 sd, 01 sw, 10 sh, 11 sb
//           st_addr        - byte address of the store
//           st_data        - register value to store
//           busy           - high whenever a store is in progress
//           done           - one-cycle completion / rejection pulse
//           misaligned     - valid with done; 1 = store rejected
//           mem            - data memory bus (master side)
module store_merge_unit #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              st_start,
    input  logic [1:0]        st_type,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              busy,
    output logic              done,
    output logic              misaligned,
    store_merge_unit_if.master mem
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE,
        REJECT
    } state_t;

    state_t            state;
    logic [1:0]        type_q;
    logic [2:0]        off_q;
    logic [DATA_W-1:0] data_q;

    logic              addr_bad;
    logic [7:0]        byte_mask;
    logic [7:0]        lane_mask;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] merged;

    // Alignment check on the incoming request, evaluated while idle.
    always_comb begin
        addr_bad = 1'b0;
        case (st_type)
            2'b00:   addr_bad = |st_addr[2:0];
            2'b01:   addr_bad = |st_addr[1:0];
            2'b10:   addr_bad = st_addr[0];
            default: addr_bad = 1'b0;
        endcase
    end

    // Byte-lane merge: the register bytes are shifted up to the addressed
    // lane and replace only those lanes of the captured read data. Alignment
    // guarantees the shifted mask never spills past byte 7.
    always_comb begin
        byte_mask = 8'h01;
        case (type_q)
            2'b00:   byte_mask = 8'hFF;
            2'b01:   byte_mask = 8'h0F;
            2'b10:   byte_mask = 8'h03;
            default: byte_mask = 8'h01;
        endcase
        lane_mask = byte_mask << off_q;
        shifted   = data_q << {off_q, 3'b000};
        merged    = '0;
        for (int i = 0; i < 8; i++) begin
            merged[i*8 +: 8] = lane_mask[i] ? shifted[i*8 +: 8] : mem.mem_rdata[i*8 +: 8];
        end
    end

    // Store sequencer. All outputs are registered and set on entry to the
    // state that owns them, so mem_rd/mem_wr/done are single-cycle pulses
    // by construction and can never overlap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            type_q        <= '0;
            off_q         <= '0;
            data_q        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            misaligned    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_rd    <= 1'b0;
            mem.mem_wr    <= 1'b0;
            mem.mem_wdata <= '0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            mem.mem_rd <= 1'b0;
            mem.mem_wr <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (st_start) begin
                        type_q       <= st_type;
                        off_q        <= st_addr[2:0];
                        data_q       <= st_data;
                        mem.mem_addr <= {st_addr[ADDR_W-1:3], 3'b000};
                        busy         <= 1'b1;
                        if (addr_bad) begin
                            state      <= REJECT;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else if (st_type == 2'b00) begin
                            state         <= WRITE;
                            mem.mem_wr    <= 1'b1;
                            mem.mem_wdata <= st_data;
                        end else begin
                            state      <= READ;
                            mem.mem_rd <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        state         <= WRITE;
                        mem.mem_wr    <= 1'b1;
                        mem.mem_wdata <= merged;
                    end
                end
                WRITE: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE, REJECT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit
// Purpose : directed scoreboard bench for store_merge_unit. Stimulus pushes
//           expected memory writes and done/misaligned results into queues;
//           a monitor pops and compares whenever the DUT writes or signals
//           done. The stimulus task also plays the memory read side.
module tb_store_merge_unit;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    logic        clk;
    logic        reset_n;
    logic        st_start;
    logic [1:0]  st_type;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic        busy;
    logic        done;
    logic        misaligned;

    store_merge_unit_if #(.ADDR_W(64)) mem_bus ();

    store_merge_unit #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .st_start   (st_start),
        .st_type    (st_type),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .busy       (busy),
        .done       (done),
        .misaligned (misaligned),
        .mem        (mem_bus.master)
    );

    int          checks = 0;
    int          errors = 0;
    int          rd_count = 0;
    logic [63:0] exp_rd_addr = '0;
    wr_t         wr_q[$];
    logic        mis_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    // Monitor: scores every memory write, read request and done pulse.
    always @(negedge clk) begin : monitor
        wr_t w;
        if (reset_n) begin
            if (mem_bus.mem_rd && mem_bus.mem_wr) begin
                checks++;
                errors++;
                $display("[TB] FAIL rd_wr_overlap: mem_rd and mem_wr both high");
            end
            if (mem_bus.mem_rd) begin
                rd_count++;
                checkOutput("rd_addr", mem_bus.mem_addr, exp_rd_addr);
            end
            if (mem_bus.mem_wr) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: addr 0x%h data 0x%h",
                             mem_bus.mem_addr, mem_bus.mem_wdata);
                end else begin
                    w = wr_q.pop_front();
                    checkOutput("wr_addr", mem_bus.mem_addr, w.addr);
                    checkOutput("wr_data", mem_bus.mem_wdata, w.data);
                end
            end
            if (done) begin
                if (mis_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: misaligned=%0b", misaligned);
                end else begin
                    checkOutput("misaligned", 64'(misaligned), 64'(mis_q.pop_front()));
                end
            end
        end
    end

    // Issues one store, answers its read after rd_lat cycles, waits for done
    // and checks latency, read count and return to idle.
    task automatic applyStimulus(input logic [1:0] typ, input logic [63:0] addr,
                                 input logic [63:0] data, input logic [63:0] rdata,
                                 input int rd_lat, input logic exp_mis,
                                 input logic [63:0] exp_wdata, input int exp_lat,
                                 input int exp_rds, input bit poke);
        wr_t w;
        int  cycles = 0;
        int  countdown = -1;
        bit  finished = 0;
        rd_count    = 0;
        exp_rd_addr = addr & ~64'h7;
        if (!exp_mis) begin
            w.addr = addr & ~64'h7;
            w.data = exp_wdata;
            wr_q.push_back(w);
        end
        mis_q.push_back(exp_mis);
        @(negedge clk);
        st_start = 1'b1;
        st_type  = typ;
        st_addr  = addr;
        st_data  = data;
        while (!finished && cycles < 60) begin
            @(negedge clk);
            cycles++;
            st_start = poke && (cycles == 2 || cycles == 3);
            if (mem_bus.mem_rvalid) mem_bus.mem_rvalid = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    mem_bus.mem_rvalid = 1'b1;
                    mem_bus.mem_rdata  = rdata;
                    countdown          = -1;
                end
            end
            if (mem_bus.mem_rd) countdown = rd_lat;
            if (poke && !done) checkOutput("busy_hold", 64'(busy), 64'd1);
            if (done) finished = 1;
        end
        st_start = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: no done within %0d cycles", cycles);
        end else begin
            checkOutput("latency", 64'(cycles), 64'(exp_lat));
        end
        checkOutput("rd_count", 64'(rd_count), 64'(exp_rds));
        @(negedge clk);
        mem_bus.mem_rvalid = 1'b0;
        checkOutput("idle_busy", 64'(busy), 64'd0);
        checkOutput("idle_done", 64'(done), 64'd0);
    endtask

    // Starts an sb, asserts reset while it waits for read data, and checks
    // that everything clears and nothing is written afterwards.
    task automatic resetInWait();
        int cycles = 0;
        rd_count    = 0;
        exp_rd_addr = 64'h300;
        @(negedge clk);
        st_start = 1'b1;
        st_type  = 2'b11;
        st_addr  = 64'h305;
        st_data  = 64'h77;
        @(negedge clk);
        st_start = 1'b0;
        while (!mem_bus.mem_rd && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("reset_test_rd_seen", 64'(mem_bus.mem_rd), 64'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_mem_rd", 64'(mem_bus.mem_rd), 64'd0);
        checkOutput("rst_mem_wr", 64'(mem_bus.mem_wr), 64'd0);
        checkOutput("rst_mem_addr", mem_bus.mem_addr, 64'h0);
        checkOutput("rst_mem_wdata", mem_bus.mem_wdata, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 64'hCAFEF00DCAFEF00D;
        @(negedge clk);
        mem_bus.mem_rvalid = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("post_rst_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        reset_n            = 1'b0;
        st_start           = 1'b0;
        st_type            = 2'b00;
        st_addr            = '0;
        st_data            = '0;
        mem_bus.mem_rdata  = '0;
        mem_bus.mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("init_busy", 64'(busy), 64'd0);
        checkOutput("init_done", 64'(done), 64'd0);
        checkOutput("init_mem_wr", 64'(mem_bus.mem_wr), 64'd0);
        checkOutput("init_mem_addr", mem_bus.mem_addr, 64'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // sd: direct write, no read
        applyStimulus(2'b00, 64'h40, 64'h1122334455667788, 64'h0, 1, 1'b0,
                      64'h1122334455667788, 2, 0, 0);
        // sw to upper word
        applyStimulus(2'b01, 64'h84, 64'hFFFFFFFFDEADBEEF, 64'h0123456789ABCDEF, 1, 1'b0,
                      64'hDEADBEEF89ABCDEF, 4, 1, 0);
        // sh at offset 6
        applyStimulus(2'b10, 64'hC6, 64'h000000000000A5A5, 64'h0, 1, 1'b0,
                      64'hA5A5000000000000, 4, 1, 0);
        // sb at offset 3 over all-ones
        applyStimulus(2'b11, 64'h203, 64'h0, 64'hFFFFFFFFFFFFFFFF, 1, 1'b0,
                      64'hFFFFFFFF00FFFFFF, 4, 1, 0);
        // misaligned sw, sh, sd
        applyStimulus(2'b01, 64'h102, 64'h12345678, 64'h0, 1, 1'b1, 64'h0, 1, 0, 0);
        applyStimulus(2'b10, 64'h101, 64'h1234, 64'h0, 1, 1'b1, 64'h0, 1, 0, 0);
        applyStimulus(2'b00, 64'h104, 64'h1, 64'h0, 1, 1'b1, 64'h0, 1, 0, 0);
        // sb with read data delayed 5 cycles, st_start poked while busy
        applyStimulus(2'b11, 64'h305, 64'h5A, 64'h1111111111111111, 5, 1'b0,
                      64'h11115A1111111111, 8, 1, 1);
        repeat (3) @(negedge clk);
        // same sb, reset while waiting for read data
        resetInWait();

        checkOutput("wr_q_drained", 64'(wr_q.size()), 64'd0);
        checkOutput("mis_q_drained", 64'(mis_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
